// File: rtl/wb_dual_arbiter_if.sv
// Pipelined Wishbone link between one master and one slave.
interface wb_dual_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, stall
  );
endinterface

// File: rtl/wb_dual_arbiter.sv
// Two-master pipelined Wishbone arbiter granting whole cyc tenures.
// Define WB_ARB_RR_EN for round-robin ties; default is fixed m0 priority.
module wb_dual_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_dual_arbiter_if.slave    m0,
  wb_dual_arbiter_if.slave    m1,
  wb_dual_arbiter_if.master   s,
  output logic [1:0]          gnt_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  logic          busy;
  logic          acc;
  logic          ackv;
  logic          own_cyc;

`ifdef WB_ARB_RR_EN
  logic last_q, last_d;
`endif

  assign full = (cnt_q == CMAX);
  assign busy = (cnt_q != '0);
  assign acc  = s.stb & ~s.stall;
  assign ackv = s.ack & busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef WB_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef WB_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef WB_ARB_RR_EN
    last_d  = last_q;
`endif
    own_cyc = (state_q == GNT1) ? m1.cyc : m0.cyc;
    unique case (state_q)
      IDLE: begin
        if (m0.cyc & m1.cyc) begin
`ifdef WB_ARB_RR_EN
          state_d = last_q ? GNT0 : GNT1;
`else
          state_d = GNT0;
`endif
        end else if (m0.cyc) begin
          state_d = GNT0;
        end else if (m1.cyc) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        // Dropping cyc aborts anything still in flight.
        if (!own_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef WB_ARB_RR_EN
          last_d  = (state_q == GNT1);
`endif
        end else if (acc & ~ackv) begin
          cnt_d = cnt_q + CW'(1);
        end else if (ackv & ~acc) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = (state_q == GNT1) ? m1.we    : m0.we;
    s.sel    = (state_q == GNT1) ? m1.sel   : m0.sel;
    s.adr    = (state_q == GNT1) ? m1.adr   : m0.adr;
    s.dat_w  = (state_q == GNT1) ? m1.dat_w : m0.dat_w;
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    m0.stall = 1'b1;
    m1.stall = 1'b1;
    gnt_o    = 2'b00;
    unique case (state_q)
      GNT0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.cyc & m0.stb & ~full;
        m0.ack   = ackv;
        m0.stall = s.stall | full;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.cyc & m1.stb & ~full;
        m1.ack   = ackv;
        m1.stall = s.stall | full;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_dual_arbiter.sv
// Randomized bench for wb_dual_arbiter against a tenure-level model.
module tb_wb_dual_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  wb_dual_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  wb_dual_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  wb_dual_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  wb_dual_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt_o (gnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: owner 0=none 1=m0 2=m1, outstanding count, last owner
  int own = 0, mcnt = 0, mlast = 2;
  int cyc_n = 0;

  bit          mc[2], ms[2], mwe[2];
  logic [3:0]  msel[2];
  logic [31:0] madr[2], mdat[2];

  bit rnd_mode = 0;
  bit rcyc[2];
  int want[2], issued[2], acked[2], ack_seen[2];
  bit rep[2], abort[2];

  bit ack_en = 1, force_ack = 0;
  int stall_pct = 0, lat_min = 2, lat_max = 2;
  int pend[$];

  bit       e_scyc, e_sstb, e_ack[2], e_stall[2];
  bit [1:0] e_gnt;
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] gseq[$];

  function automatic void predict();
    int k;
    e_scyc = 0; e_sstb = 0; e_gnt = 2'b00;
    e_ack[0] = 0; e_ack[1] = 0;
    e_stall[0] = 1; e_stall[1] = 1;
    if (own != 0) begin
      k = own - 1;
      e_scyc = mc[k];
      e_sstb = mc[k] && ms[k] && (mcnt < MAX);
      e_ack[k] = s_if.ack && (mcnt > 0);
      e_stall[k] = s_if.stall || (mcnt == MAX);
      e_gnt = (own == 1) ? 2'b01 : 2'b10;
    end
  endfunction

  task automatic drive();
    for (int x = 0; x < 2; x++) begin
      if (rnd_mode) begin
        mc[x] = rcyc[x];
        ms[x] = mc[x] && ($urandom_range(9) < 7);
      end else begin
        mc[x] = (acked[x] < want[x]) && !abort[x];
        ms[x] = mc[x] && (issued[x] < want[x]);
      end
      mwe[x]  = 1'($urandom_range(1));
      msel[x] = 4'($urandom);
      madr[x] = $urandom;
      mdat[x] = $urandom;
    end
    m0_if.cyc = mc[0]; m0_if.stb = ms[0]; m0_if.we = mwe[0];
    m0_if.sel = msel[0]; m0_if.adr = madr[0]; m0_if.dat_w = mdat[0];
    m1_if.cyc = mc[1]; m1_if.stb = ms[1]; m1_if.we = mwe[1];
    m1_if.sel = msel[1]; m1_if.adr = madr[1]; m1_if.dat_w = mdat[1];
    s_if.ack = 1'b0;
    s_if.stall = ($urandom_range(99) < stall_pct);
    s_if.dat_r = $urandom;
    predict();
    s_if.ack = force_ack ||
      (ack_en && e_scyc && pend.size() > 0 && pend[0] <= cyc_n);
    predict();
  endtask

  task automatic begin_cycle();
    int k;
    drive();
    #3;
    chk("gnt", gnt, e_gnt);
    chk("s_cyc", s_if.cyc, e_scyc);
    chk("s_stb", s_if.stb, e_sstb);
    chk("m0_ack", m0_if.ack, e_ack[0]);
    chk("m1_ack", m1_if.ack, e_ack[1]);
    chk("m0_stall", m0_if.stall, e_stall[0]);
    chk("m1_stall", m1_if.stall, e_stall[1]);
    chk("m0_dat", m0_if.dat_r, s_if.dat_r);
    chk("m1_dat", m1_if.dat_r, s_if.dat_r);
    if (own != 0) begin
      k = own - 1;
      chk("s_we", s_if.we, mwe[k]);
      chk("s_sel", s_if.sel, msel[k]);
      chk("s_adr", s_if.adr, madr[k]);
      chk("s_dat", s_if.dat_w, mdat[k]);
    end
    if (gnt != 2'b00 && prev_gnt == 2'b00) gseq.push_back(gnt);
    prev_gnt = gnt;
  endtask

  task automatic end_cycle();
    int k;
    bit acc, ak;
    for (int x = 0; x < 2; x++) begin
      if (e_ack[x]) acked[x]++;
      if (x == 0 ? m0_if.ack : m1_if.ack) ack_seen[x]++;
      if (ms[x] && !e_stall[x]) issued[x]++;
      if (!rnd_mode && rep[x] && !mc[x] && !abort[x]) begin
        issued[x] = 0;
        acked[x] = 0;
      end
      if (rnd_mode) begin
        if (rcyc[x]) rcyc[x] = ($urandom_range(7) != 0);
        else rcyc[x] = ($urandom_range(3) == 0);
      end
    end
    acc = e_sstb && !s_if.stall;
    ak  = s_if.ack && (mcnt > 0);
    if (rst || !e_scyc) pend.delete();
    else begin
      if (s_if.ack && pend.size() > 0) void'(pend.pop_front());
      if (acc) pend.push_back(cyc_n + $urandom_range(lat_max, lat_min));
    end
    if (rst) begin
      own = 0; mcnt = 0; mlast = 2;
    end else if (own == 0) begin
      if (mc[0] && mc[1]) begin
`ifdef WB_ARB_RR_EN
        own = (mlast == 2) ? 1 : 2;
`else
        own = 1;
`endif
      end else if (mc[0]) own = 1;
      else if (mc[1]) own = 2;
    end else begin
      k = own - 1;
      if (!mc[k]) begin
        mlast = own; own = 0; mcnt = 0;
      end else begin
        mcnt = mcnt + int'(acc) - int'(ak);
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic step();
    begin_cycle();
    end_cycle();
  endtask

  task automatic clr_masters();
    for (int x = 0; x < 2; x++) begin
      want[x] = 0; issued[x] = 0; acked[x] = 0;
      rep[x] = 0; abort[x] = 0;
    end
  endtask

  int base;

  initial begin
    clr_masters();
    rst = 1'b1;
    want[0] = 1; want[1] = 1;
    @(posedge clk);
    #1;
    // reset with both masters requesting
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      chk("t1_gnt", gnt, 2'b00);
      chk("t1_scyc", s_if.cyc, 1'b0);
      chk("t1_stall0", m0_if.stall, 1'b1);
      chk("t1_stall1", m1_if.stall, 1'b1);
      end_cycle();
    end
    clr_masters();
    rst = 1'b0;
    step();

    // m1 alone, 8 strobes, latency 2
    want[1] = 8;
    ack_seen[0] = 0; ack_seen[1] = 0;
    begin_cycle();
    chk("t2_gnt_idle", gnt, 2'b00);
    end_cycle();
    begin_cycle();
    chk("t2_gnt", gnt, 2'b10);
    end_cycle();
    for (int i = 0; i < 50 && !(own == 0 && acked[1] >= 8); i++) step();
    chk("t2_done", own == 0 && acked[1] >= 8, 1);
    begin_cycle();
    chk("t2_idle", gnt, 2'b00);
    chk("t2_acks1", ack_seen[1], 8);
    chk("t2_acks0", ack_seen[0], 0);
    end_cycle();

    // slave withholds acks
    clr_masters();
    want[1] = 10;
    ack_en = 0;
    base = ack_seen[1];
    for (int i = 0; i < 14; i++) step();
    begin_cycle();
    chk("t3_stall", m1_if.stall, 1'b1);
    chk("t3_issued", issued[1], 8);
    end_cycle();
    ack_en = 1;
    for (int i = 0; i < 60 && !(own == 0 && acked[1] >= 10); i++) step();
    chk("t3_acks", ack_seen[1] - base, 10);

    // tie handling
    rst = 1'b1;
    step();
    rst = 1'b0;
    clr_masters();
    gseq.delete();
    want[0] = 2; want[1] = 2; rep[0] = 1; rep[1] = 1;
    for (int i = 0; i < 200 && gseq.size() < 3; i++) step();
    chk("t4_count", gseq.size() >= 3, 1);
    if (gseq.size() >= 3) begin
      chk("t4_g0", gseq[0], 2'b01);
`ifdef WB_ARB_RR_EN
      chk("t4_g1", gseq[1], 2'b10);
`else
      chk("t4_g1", gseq[1], 2'b01);
`endif
      chk("t4_g2", gseq[2], 2'b01);
    end
    rep[0] = 0; rep[1] = 0;
    for (int i = 0; i < 200 && !(own == 0 && acked[0] >= want[0] &&
         acked[1] >= want[1]); i++) step();
    chk("t4_drain", own == 0 && acked[1] >= want[1], 1);

    // abort with in-flight strobes, m1 waiting
    clr_masters();
    step();
    want[0] = 3;
    ack_en = 0;
    for (int i = 0; i < 20 && issued[0] < 3; i++) step();
    chk("t5_issued", issued[0], 3);
    want[1] = 1;
    abort[0] = 1;
    step();
    step();
    force_ack = 1;
    base = ack_seen[1];
    begin_cycle();
    chk("t5_gnt", gnt, 2'b10);
    chk("t5_noack", m1_if.ack, 1'b0);
    end_cycle();
    force_ack = 0;
    abort[0] = 0; want[0] = 0; issued[0] = 0;
    ack_en = 1;
    for (int i = 0; i < 30 && !(own == 0 && acked[1] >= 1); i++) step();
    chk("t5_m1_acks", ack_seen[1] - base, 1);

    // accept + ack in one cycle at cnt 5, then reset
    clr_masters();
    step();
    want[1] = 12;
    ack_en = 0;
    for (int i = 0; i < 20 && issued[1] < 5; i++) step();
    chk("t6_issued5", issued[1], 5);
    force_ack = 1;
    step();
    force_ack = 0;
    for (int i = 0; i < 6; i++) step();
    begin_cycle();
    chk("t6_stall", m1_if.stall, 1'b1);
    chk("t6_issued9", issued[1], 9);
    end_cycle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clr_masters();
    begin_cycle();
    chk("t6_gnt_rst", gnt, 2'b00);
    end_cycle();

    // random traffic
    ack_en = 1;
    stall_pct = 20;
    lat_min = 1;
    lat_max = 4;
    rnd_mode = 1;
    rcyc[0] = 0; rcyc[1] = 0;
    for (int i = 0; i < 3000; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
